// File: rtl/cargador_matrices.sv
// cargador_matrices: unpacks a framed host byte stream into the 4x4 operand bank,
// then raises Start, waits for the multiplier's Done and clears Start again.
module cargador_matrices #(
    parameter int          Width   = 32,
    parameter int          TIMEOUT = 1000,
    parameter logic [7:0]  HEADER  = 8'hA5
) (
    input  logic             CLK,
    input  logic             MasterReset,
    input  logic [7:0]       InByte,
    input  logic             InValid,
    output logic             InReady,
    input  logic             Done,
    output logic [Width-1:0] InDatos,
    output logic             Write,
    output logic [8:0]       Address,
    output logic             Busy,
    output logic             FrameError
);
    localparam int IW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {HUNT, DATA, GO, WAIT, CLEAR} state_t;
    state_t           state_q, state_d;
    logic [5:0]       count_q, count_d;
    logic [IW-1:0]    idle_q, idle_d;
    logic             write_q, write_d, busy_q, busy_d, ferr_q, ferr_d;
    logic [8:0]       addr_q, addr_d;
    logic [Width-1:0] datos_q, datos_d;
    logic             acc;
    logic [IW-1:0]    idle_inc;
    assign InReady    = (state_q == HUNT) || (state_q == DATA);
    assign acc        = InValid && InReady;
    assign idle_inc   = idle_q + 1'b1;
    assign Write      = write_q;
    assign Address    = addr_q;
    assign InDatos    = datos_q;
    assign Busy       = busy_q;
    assign FrameError = ferr_q;
    // Every output is registered, so a decision taken in cycle t is visible in t+1.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idle_d  = idle_q;
        write_d = 1'b0;
        addr_d  = addr_q;
        datos_d = '0;
        busy_d  = busy_q;
        ferr_d  = 1'b0;
        case (state_q)
            HUNT: if (acc && InByte == HEADER) begin
                state_d = DATA;
                count_d = '0;
                idle_d  = '0;
                busy_d  = 1'b1;
            end
            DATA: if (acc) begin
                write_d = 1'b1;
                addr_d  = {3'b000, count_q};
                datos_d = Width'(InByte);
                count_d = count_q + 1'b1;
                idle_d  = '0;
                state_d = (count_q == 6'd63) ? GO : DATA;
            end else if (idle_inc == IW'(TIMEOUT)) begin
                ferr_d  = 1'b1;
                idle_d  = '0;
                busy_d  = 1'b0;
                state_d = HUNT;
            end else begin
                idle_d  = idle_inc;
            end
            GO: begin
                write_d = 1'b1;
                addr_d  = 9'd64;
                datos_d = Width'(1);
                state_d = WAIT;
            end
            // The Start-clear write is issued on the Done edge so it lands the next cycle.
            WAIT: if (Done) begin
                write_d = 1'b1;
                addr_d  = 9'd64;
                state_d = CLEAR;
            end
            CLEAR: begin
                busy_d  = 1'b0;
                state_d = HUNT;
            end
            default: state_d = HUNT;
        endcase
    end
    always_ff @(posedge CLK or posedge MasterReset) begin
        if (MasterReset) begin
            state_q <= HUNT;
            count_q <= '0;
            idle_q  <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            datos_q <= '0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idle_q  <= idle_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            datos_q <= datos_d;
            busy_q  <= busy_d;
            ferr_q  <= ferr_d;
        end
    end
endmodule

// File: tb/tb_cargador_matrices.sv
// tb_cargador_matrices: random frame traffic checked cycle by cycle against a frame-level model.
module tb_cargador_matrices;
    localparam int         W   = 32;
    localparam int         TO  = 8;
    localparam logic [7:0] HDR = 8'hA5;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   in_byte = '0;
    logic         in_valid = 1'b0;
    logic         done = 1'b0;
    logic         in_ready, wr, busy, ferr;
    logic [W-1:0] datos;
    logic [8:0]   addr;
    int           total = 0;
    int           bad = 0;
    logic         tog = 1'b0;
    logic [7:0]   fb [64];
    // Frame-level model: where the loader is in the frame and what it owes the bank next cycle.
    int           m_phase;
    int           m_pos;
    int           m_idle;
    logic         m_wr, m_busy, m_ferr;
    logic [8:0]   m_addr;
    logic [W-1:0] m_data;
    always #5 clk = ~clk;
    cargador_matrices #(.Width(W), .TIMEOUT(TO), .HEADER(HDR)) dut (
        .CLK(clk), .MasterReset(rst), .InByte(in_byte), .InValid(in_valid), .InReady(in_ready),
        .Done(done), .InDatos(datos), .Write(wr), .Address(addr), .Busy(busy), .FrameError(ferr)
    );
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask
    task automatic model_reset;
        m_phase = 0; m_pos = 0; m_idle = 0;
        m_wr = 0; m_busy = 0; m_ferr = 0; m_addr = '0; m_data = '0;
    endtask
    task automatic step(input logic v, input logic [7:0] b, input logic d);
        logic rdy;
        in_valid = v; in_byte = b; done = d;
        rdy = (m_phase < 2);
        @(negedge clk);
        chk("ready", in_ready, rdy);
        chk("write", wr, m_wr);
        chk("addr", addr, m_addr);
        chk("datos", datos, m_wr ? m_data : '0);
        chk("busy", busy, m_busy);
        chk("ferr", ferr, m_ferr);
        m_wr = 0; m_data = '0; m_ferr = 0;
        if (m_phase == 0) begin
            if (v && b == HDR) begin m_phase = 1; m_pos = 0; m_idle = 0; m_busy = 1; end
        end else if (m_phase == 1) begin
            if (v) begin
                m_wr = 1; m_addr = 9'(m_pos); m_data = W'(b); m_idle = 0; m_pos++;
                if (m_pos == 64) m_phase = 2;
            end else if (++m_idle == TO) begin
                m_ferr = 1; m_phase = 0; m_busy = 0; m_idle = 0;
            end
        end else if (m_phase == 2) begin
            m_wr = 1; m_addr = 9'd64; m_data = 1; m_phase = 3;
        end else if (m_phase == 3) begin
            if (d) begin m_wr = 1; m_addr = 9'd64; m_data = 0; m_phase = 4; end
        end else begin
            m_phase = 0; m_busy = 0;
        end
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [7:0] b, input int mode);
        logic v, acc;
        acc = 0;
        for (int i = 0; i < 16 && !acc; i++) begin
            if (mode == 1) begin v = tog; tog = ~tog; end
            else v = (mode == 0) || ($urandom_range(0, 2) != 0);
            acc = v && (m_phase < 2);
            step(v, v ? b : 8'($urandom), (mode == 2) ? 1'($urandom) : 1'b0);
        end
        chk("accepted", 64'(acc), 64'd1);
    endtask
    task automatic frame(input int mode);
        send(HDR, mode);
        for (int i = 0; i < 64; i++) send(fb[i], mode);
    endtask
    task automatic finish_frame(input int n);
        repeat (n) step(0, 8'h00, 0);
        step(0, 8'h00, 1);
        repeat (2) step(0, 8'h00, 0);
    endtask
    task automatic apply_reset;
        in_valid = 0; done = 0;
        #2 rst = 1;
        #1;
        chk("rst_write", wr, 0);
        chk("rst_addr", addr, 0);
        chk("rst_datos", datos, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_ready", in_ready, 1);
        @(posedge clk);
        #1 rst = 0;
        model_reset();
    endtask
    initial begin
        model_reset();
        apply_reset();
        for (int i = 0; i < 64; i++) fb[i] = 8'(i);
        frame(0);
        finish_frame(20);
        send(8'h12, 0);
        send(8'hFF, 0);
        for (int i = 0; i < 64; i++) fb[i] = 8'($urandom);
        frame(0);
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);
        repeat (3) step(0, 8'h00, 0);
        send(HDR, 0);
        for (int i = 0; i < 10; i++) send(8'($urandom), 0);
        repeat (12) step(0, 8'h00, 0);
        for (int i = 0; i < 64; i++) fb[i] = 8'($urandom);
        frame(0);
        finish_frame(3);
        for (int i = 0; i < 64; i++) fb[i] = 8'($urandom);
        fb[5] = 8'h80;
        frame(1);
        finish_frame(2);
        for (int r = 0; r < 4; r++) begin
            send(8'($urandom_range(0, 8'hA4)), 2);
            for (int i = 0; i < 64; i++) fb[i] = 8'($urandom);
            fb[7] = HDR;
            frame(2);
            finish_frame($urandom_range(1, 10));
        end
        send(HDR, 0);
        for (int i = 0; i < 30; i++) send(8'($urandom), 0);
        apply_reset();
        for (int i = 0; i < 64; i++) fb[i] = 8'($urandom);
        frame(0);
        finish_frame(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end
endmodule
